// File: rtl/serial_cla_subtractor.sv
// serial_cla_subtractor: multi-cycle subtractor computing diff = a - b - bin.
// One 4-bit carry-look-ahead slice (a + ~b + carry) is evaluated per clock,
// least-significant slice first. The slice carry-out is kept in a register
// and feeds the next slice.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE.
// Optional feature: define SUB_FLAGS_EN to add the registered zero/ovf outputs.
module serial_cla_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Reject widths that cannot be split into whole 4-bit slices.
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("serial_cla_subtractor: WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            carry_q, carry_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic            bout_q, bout_d;
`ifdef SUB_FLAGS_EN
    logic            zacc_q, zacc_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
`endif

    logic [3:0] sl_a, sl_nb, sl_g, sl_p, sl_s;
    logic [4:0] sl_c;

    // Current slice: 4-bit carry-look-ahead adder on a + ~b + carry.
    always_comb begin
        sl_a  = a_q[{cnt_q, 2'b00} +: 4];
        sl_nb = ~b_q[{cnt_q, 2'b00} +: 4];
        sl_g  = sl_a & sl_nb;
        sl_p  = sl_a ^ sl_nb;
        sl_c[0] = carry_q;
        sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
        sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_s = sl_p ^ sl_c[3:0];
    end

    // Next-state and datapath updates for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_FLAGS_EN
        zacc_d  = zacc_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~bin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SUB_FLAGS_EN
                    zacc_d  = 1'b1;
`endif
                end
            end
            RUN: begin
                diff_d[{cnt_q, 2'b00} +: 4] = sl_s;
                carry_d = sl_c[4];
`ifdef SUB_FLAGS_EN
                zacc_d  = zacc_q & (sl_s == 4'd0);
`endif
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    // carry-out of a + ~b + ~bin is the inverse of borrow-out
                    bout_d  = ~sl_c[4];
`ifdef SUB_FLAGS_EN
                    zero_d  = zacc_q & (sl_s == 4'd0);
                    // last slice holds the MSB of the result
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sl_s[3] != a_q[WIDTH-1]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_FLAGS_EN
            zacc_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUB_FLAGS_EN
            zacc_q  <= zacc_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SUB_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: doc/serial_cla_subtractor.md
Name: serial_cla_subtractor

Overview:
- Multi-cycle subtractor computing diff = a - b - bin over WIDTH bits.
- Processes one 4-bit slice per clock, least-significant slice first.
- Each slice is a carry-look-ahead adder evaluated as a + ~b + carry; the slice carry-out feeds the next slice through a register.
- Sits beside the combinational adder datapath: it is the subtract/borrow direction of the same arithmetic interface, with valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operands a, b, bin are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 when a < b + bin (unsigned).

Behaviour:
- Slice count is N = WIDTH/4. Slice counter width is clog2(N), minimum 1 bit.
- Reset (rst=1 at a clock edge, in any state):
  - state goes to IDLE and the slice counter to 0;
  - diff=0, bout=0, out_valid=0, in_ready=1;
  - operand registers and the carry register are cleared;
  - an operation in flight is discarded and no result is produced.
- IDLE:
  - in_ready=1.
  - When in_valid=1, operands are accepted. The block registers a and b, sets carry = ~bin and counter = 0, and moves to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, slice k = counter is computed as s = a[4k+3:4k] + ~b[4k+3:4k] + carry, using 4-bit carry-look-ahead (generate/propagate) logic.
  - s is written to diff[4k+3:4k], and carry takes the slice carry-out.
  - When counter = N-1, the state moves to DONE and bout is registered as ~(final carry-out). Otherwise the counter increments.
- DONE:
  - out_valid=1. diff and bout are held stable.
  - When out_ready=1, the state moves to IDLE.
  - No operand is accepted in DONE, even if out_ready=1 in the same cycle.
- Latency:
  - If operands are accepted in cycle C, RUN occupies cycles C+1 to C+N and out_valid is first high in cycle C+N+1.
  - Minimum issue interval is N+2 cycles.
- Backpressure: while out_ready=0, DONE holds indefinitely, with outputs unchanged and in_ready=0.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- diff bits of slices not yet written are undefined during RUN. Consumers read diff only while out_valid=1.
- Wrap-around: the result is modulo 2^WIDTH. Underflow is signalled only through bout.

Optional Feature:
- Macro: SUB_FLAGS_EN.
- When defined, two extra output ports are added, both registered at the DONE transition, held through DONE, and cleared by reset:
  - zero  output  1  diff == 0.
  - ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
- For zero, the flag accumulates per slice as AND of (s == 0) across all slices.
- When not defined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Basic subtraction (WIDTH=16): a=0x1234, b=0x0234, bin=0, out_ready=1 -> out_valid first high 5 cycles after the accept cycle, diff=0x1000, bout=0; in_ready high again the cycle after DONE.
- Underflow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1.
- Borrow-in: a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0. Then a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1.
- Cross-slice borrow chain: a=0x1000, b=0x0001 -> diff=0x0FFF, bout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> out_valid, diff and bout stay unchanged; in_ready=0; new operands are not accepted. Raise out_ready -> IDLE next cycle; the new operands are accepted only from IDLE.
- Reset mid-operation: assert rst in the 2nd RUN cycle -> next cycle shows IDLE, out_valid=0, diff=0, bout=0, in_ready=1; no stale result ever appears.
- Flags (with SUB_FLAGS_EN):
  - a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, zero=0, bout=0.
  - a=b=0x5555 -> diff=0, zero=1, ovf=0.
